// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into big-endian 32-bit words. The completed word is
// presented combinationally in the cycle its last byte is accepted, so the
// caller can register it into the memory port with no extra latency.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_q, in_byte};

  // Byte counter wraps after the fourth byte, ready for the next word.
  always_ff @(posedge clk) begin
    if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], in_byte};
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction memory loader: byte stream in, consecutive word writes out.
// Build option: define LOADER_CHECKSUM_EN to expect a 4-byte trailer holding
// the 32-bit sum of the payload words; a mismatch raises a sticky error.
//
// state | meaning
// IDLE  | waiting for start, no bytes accepted
// LOAD  | accepting payload bytes, one write per 4 bytes
// CHECK | accepting the checksum trailer word
// DONE  | load finished, done pulses in the following cycle
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LOAD = CHECK;
`else
  localparam loader_state_t AFTER_LOAD = DONE;
`endif

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   index_q;
  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = in_valid && in_ready;
  assign start_ok  = (state == IDLE) && start;
  assign last_word = ((index_q + ONE) == count_q);

  word_assembler u_asm (
    .clk        (clk),
    .clear      (reset || start_ok),
    .accept     (accept),
    .in_byte    (in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? DONE : LOAD;
      LOAD:    if (word_valid && last_word) state_nxt = AFTER_LOAD;
      CHECK:   if (word_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status outputs; done trails the DONE state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_nxt == LOAD) || (state_nxt == CHECK);
      busy     <= (state_nxt == LOAD) || (state_nxt == CHECK);
      done     <= (state == DONE);
    end
  end

  // Load parameters, word index and the memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      count_q   <= '0;
      index_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        base_q  <= base_addr;
        count_q <= word_count;
        index_q <= '0;
      end else if ((state == LOAD) && word_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= base_q + index_q[ADDR_W-1:0];
        mem_wdata <= word;
        index_q   <= index_q + ONE;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        error_q;

  // Running payload sum and trailer comparison; error sticks until next start.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if ((state == LOAD) && word_valid) begin
      csum_q <= csum_q + word;
    end else if ((state == CHECK) && word_valid && (word != csum_q)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
